// File: rtl/alu_seq.sv
// Sequential ALU with a handshake on each side. Shifts move one bit per cycle,
// and every other op completes one cycle after it is accepted.
package alu_pkg;
  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SRL   = 4'd3,
    ALU_SRA   = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_OR    = 4'd6,
    ALU_AND   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_LUI   = 4'd10,
    ALU_AUIPC = 4'd11
  } alu_operation_type;
endpackage

module alu_seq
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  alu_operation_type op,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   result,
  output logic              zero
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]        state_q, state_d;
  alu_operation_type op_q, op_d;
  logic [XLEN-1:0]   wrk_q, wrk_d;
  logic [SHW-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]   res_q, res_d;

  logic [SHW-1:0]    shamt;
  logic [XLEN-1:0]   step_val;

  function automatic logic is_shift(input alu_operation_type o);
    return (o == ALU_SLL) || (o == ALU_SRL) || (o == ALU_SRA);
  endfunction

  // Single-cycle ops; a zero-amount shift passes a through unchanged.
  function automatic logic [XLEN-1:0] alu_eval(input alu_operation_type o,
                                               input logic [XLEN-1:0] x,
                                               input logic [XLEN-1:0] y);
    logic [XLEN-1:0] r;
    r = '0;
    case (o)
      ALU_ADD, ALU_AUIPC: r = x + y;
      ALU_SUB:            r = x - y;
      ALU_XOR:            r = x ^ y;
      ALU_OR:             r = x | y;
      ALU_AND:            r = x & y;
      ALU_SLT:            r = {{(XLEN-1){1'b0}}, ($signed(x) < $signed(y))};
      ALU_SLTU:           r = {{(XLEN-1){1'b0}}, (x < y)};
      ALU_LUI:            r = y;
      ALU_SLL, ALU_SRL, ALU_SRA: r = x;
      default:            r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [XLEN-1:0] shift_step(input alu_operation_type o,
                                                 input logic [XLEN-1:0] x);
    logic [XLEN-1:0] r;
    r = x;
    case (o)
      ALU_SLL: r = {x[XLEN-2:0], 1'b0};
      ALU_SRL: r = {1'b0, x[XLEN-1:1]};
      ALU_SRA: r = {x[XLEN-1], x[XLEN-1:1]};
      default: r = x;
    endcase
    return r;
  endfunction

  assign shamt    = b[SHW-1:0];
  assign step_val = shift_step(op_q, wrk_q);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wrk_d   = wrk_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d  = op;
          wrk_d = a;
          if (is_shift(op) && (shamt != '0)) begin
            cnt_d   = shamt;
            state_d = S_SHIFT;
          end else begin
            res_d   = alu_eval(op, a, b);
            state_d = S_DONE;
          end
        end
      end
      S_SHIFT: begin
        wrk_d = step_val;
        cnt_d = cnt_q - 1'b1;
        // Last step: publish the shifted value as we leave.
        if (cnt_q == SHW'(1)) begin
          res_d   = step_val;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= ALU_ADD;
      wrk_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wrk_q   <= wrk_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = res_q;
  assign zero      = (res_q == '0);

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed ops with literal expectations, plus a
// transaction-level model checked against the outputs on every cycle.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int XLEN = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  alu_operation_type op;
  logic [XLEN-1:0]   a, b;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   result;
  logic              zero;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  alu_seq #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the op means, and how many cycles it takes.
  function automatic logic [XLEN-1:0] model_res(input logic [3:0] o,
                                                input logic [XLEN-1:0] x,
                                                input logic [XLEN-1:0] y);
    int sh;
    sh = int'(y[4:0]);
    case (o)
      4'd0, 4'd11: return x + y;
      4'd1:  return x - y;
      4'd2:  return x << sh;
      4'd3:  return x >> sh;
      4'd4:  return XLEN'($signed(x) >>> sh);
      4'd5:  return x ^ y;
      4'd6:  return x | y;
      4'd7:  return x & y;
      4'd8:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd9:  return (x < y) ? 32'd1 : 32'd0;
      4'd10: return y;
      default: return '0;
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] o, input logic [XLEN-1:0] y);
    if ((o == 4'd2 || o == 4'd3 || o == 4'd4) && y[4:0] != 5'd0) return int'(y[4:0]) + 1;
    return 1;
  endfunction

  // Model transaction state: 0 idle, 1 computing, 2 result held.
  int              m_phase;
  int              m_left;
  logic [XLEN-1:0] m_pend;
  logic [XLEN-1:0] m_res;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0;
      m_res   = '0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
             m_pend = model_res(op, a, b);
             m_left = model_lat(op, b) - 1;
             if (m_left == 0) begin m_phase = 2; m_res = m_pend; end
             else m_phase = 1;
           end
        1: begin
             m_left--;
             if (m_left == 0) begin m_phase = 2; m_res = m_pend; end
           end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready",  32'(in_ready),  32'(m_phase == 0));
      check("out_valid", 32'(out_valid), 32'(m_phase == 2));
      check("result",    result, m_res);
      check("zero",      32'(zero), 32'(m_res == '0));
    end
  end

  // One transaction: literal result/latency, optional stall and input noise.
  task automatic run(input string name, input logic [3:0] o,
                     input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                     input logic [XLEN-1:0] exp, input int lat,
                     input int stall, input bit noise);
    int k;
    @(negedge clk);
    in_valid = 1'b1; op = alu_operation_type'(o); a = x; b = y;
    out_ready = (stall == 0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      in_valid = noise;
      op = noise ? ALU_ADD : op;
      a = $urandom; b = $urandom;
    end while (!out_valid && k < 100);
    in_valid = 1'b0;
    check({name, "_lat"}, 32'(k), 32'(lat));
    check({name, "_res"}, result, exp);
    if (stall > 0) begin
      repeat (stall) @(negedge clk);
      check({name, "_held"}, result, exp);
      out_ready = 1'b1;
      @(negedge clk);
      check({name, "_idle"}, 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b1; op = ALU_ADD; a = 32'd1; b = 32'd2; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    chk_en = 1'b1;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result",    result,         32'd0);
    check("rst_zero",      32'(zero),      32'd1);
    @(negedge clk);
    check("rst_no_accept", 32'(out_valid), 32'd0);

    run("add_wrap", 4'd0,  32'hFFFF_FFFF, 32'h1,          32'h0,          1,  0, 0);
    run("sra4",     4'd4,  32'h8000_0000, 32'd4,          32'hF800_0000,  5,  0, 1);
    run("srl4",     4'd3,  32'h8000_0000, 32'd4,          32'h0800_0000,  5,  0, 0);
    run("sra_pos",  4'd4,  32'h7000_0000, 32'd4,          32'h0700_0000,  5,  0, 0);
    run("slt",      4'd8,  32'hFFFF_FFFE, 32'h1,          32'h1,          1,  0, 0);
    run("sltu",     4'd9,  32'hFFFF_FFFE, 32'h1,          32'h0,          1,  0, 0);
    run("sll_sh0",  4'd2,  32'h1,         32'h20,         32'h1,          1,  0, 0);
    run("sll31",    4'd2,  32'h1,         32'd31,         32'h8000_0000,  32, 0, 1);
    run("sub_bp",   4'd1,  32'd5,         32'd7,          32'hFFFF_FFFE,  1,  3, 0);
    run("or",       4'd6,  32'hF0F0_0000, 32'h0000_0F0F,  32'hF0F0_0F0F,  1,  0, 0);
    run("and",      4'd7,  32'hFF00_FF00, 32'h0FF0_0FF0,  32'h0F00_0F00,  1,  0, 0);
    run("lui",      4'd10, 32'h1234,      32'h1234_5000,  32'h1234_5000,  1,  0, 0);
    run("auipc",    4'd11, 32'h1000,      32'h2000,       32'h3000,       1,  0, 0);
    run("bad_op",   4'd14, 32'h1234,      32'h5678,       32'h0,          1,  0, 0);

    // Abandon a long shift with reset.
    @(negedge clk);
    in_valid = 1'b1; op = ALU_SLL; a = 32'h1; b = 32'd20; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_shift_busy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_in_ready",  32'(in_ready),  32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_result",    result,         32'd0);
    run("xor", 4'd5, 32'hF0, 32'hFF, 32'h0F, 1, 0, 0);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: XLEN, default 32, datapath width; shift amount field is b[4:0] for XLEN=32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operation request present on op/a/b.
REQ-005 in_ready  output  1  block accepts a request this cycle.
REQ-006 op  input  alu_operation_type (common package)  operation code (ADD, SUB, SLL, SRL, SRA, XOR, OR, AND, SLT, SLTU, LUI, AUIPC).
REQ-007 a  input  XLEN  operand A (rs1 value, or PC for AUIPC).
REQ-008 b  input  XLEN  operand B (rs2 value or immediate; LUI/AUIPC immediate already shifted into [31:12]).
REQ-009 out_valid  output  1  result present on result/zero.
REQ-010 out_ready  input  1  consumer accepts result this cycle.
REQ-011 result  output  XLEN  operation result.
REQ-012 zero  output  1  high when result == 0.

Function
REQ-013 The block SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; request accepted when in_valid && in_ready.
REQ-015 On accept, op, a, b SHALL be captured in internal registers; inputs are don't-care afterwards.
REQ-016 Non-shift ops SHALL go IDLE -> DONE, out_valid high on the cycle after accept (latency 1).
REQ-017 ADD/AUIPC: a + b; SUB: a - b; all modulo 2^XLEN, carry discarded.
REQ-018 XOR/OR/AND: bitwise on a, b.
REQ-019 SLT: 1 if signed(a) < signed(b) else 0; SLTU: same unsigned; upper bits zero.
REQ-020 LUI: result = b, a ignored.
REQ-021 Shifts SHALL use shamt = b[4:0]; shamt 0 -> IDLE -> DONE with result = a (latency 1).
REQ-022 Shifts with shamt > 0 SHALL go IDLE -> SHIFT, shift the working register by one bit per cycle, decrement a counter, enter DONE after exactly shamt SHIFT cycles (latency shamt+1).
REQ-023 SLL fills zeros from LSB; SRL fills zeros from MSB; SRA replicates bit XLEN-1 each step.
REQ-024 Any op value outside the listed set SHALL complete as a non-shift op with result 0.
REQ-025 In DONE, out_valid SHALL be 1 and result/zero SHALL hold stable until out_valid && out_ready.
REQ-026 On output handshake the FSM SHALL return to IDLE; in_ready rises the following cycle (no same-cycle re-accept).
REQ-027 out_valid SHALL be 0 in IDLE and SHIFT; result/zero SHALL be undefined-free (hold last value) outside DONE.
REQ-028 out_ready asserted outside DONE SHALL have no effect; in_valid outside IDLE SHALL be ignored.
REQ-029 Minimum throughput: one op per 2 cycles for non-shift ops with out_ready held high.

Reset
REQ-030 With rst high at a clock edge the FSM SHALL enter IDLE, regardless of state, abandoning any in-flight op.
REQ-031 After reset: in_ready = 1, out_valid = 0, result = 0, zero = 1, shift counter = 0.
REQ-032 A request presented during a rst-high cycle SHALL NOT be accepted.

Verification
REQ-033 ADD a=0xFFFF_FFFF, b=0x1, out_ready=1 -> out_valid one cycle after accept, result=0, zero=1.
REQ-034 SRA a=0x8000_0000, b=4 -> four SHIFT cycles, out_valid on cycle 5 after accept, result=0xF800_0000; SRL same operands -> 0x0800_0000.
REQ-035 SLT a=0xFFFF_FFFE, b=0x1 -> result=1; SLTU same operands -> result=0.
REQ-036 SLL a=0x1, b=0x20 (shamt 0) -> result=0x1 at latency 1; b=31 -> result=0x8000_0000 at latency 32.
REQ-037 Backpressure: SUB a=5, b=7, out_ready=0 for 3 cycles -> result=0xFFFF_FFFE held stable, in_ready=0 throughout; release -> IDLE next cycle.
REQ-038 Reset mid-operation: assert rst during SHIFT of a 20-bit SLL -> next cycle in_ready=1, out_valid=0, result=0; subsequent XOR a=0xF0, b=0xFF -> 0x0F.
